// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths, op encodings and helpers for the operand fetch stage
package operand_fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int OPW = 3;
  localparam logic [AW-1:0] ZERO_REG = '0;
  typedef enum logic [OPW-1:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOT = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5
  } op_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
  function automatic logic wb_hit(input logic en, input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    return en && wa == ra && ra != ZERO_REG;
  endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: issue, write-back and execute-side handshake bundle
interface operand_fetch_stage_if;
  import operand_fetch_stage_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [AW-1:0] in_rd;
  logic [OPW-1:0] in_op;
  logic wb_en;
  logic [AW-1:0] wb_addr;
  logic [XLEN-1:0] wb_data;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] reg_s1;
  logic [XLEN-1:0] reg_s2;
  logic [AW-1:0] out_rd;
  logic [OPW-1:0] out_op;
  logic enable;
  modport slave (
    input in_valid, in_rs1, in_rs2, in_rd, in_op, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, reg_s1, reg_s2, out_rd, out_op, enable
  );
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_op, wb_en, wb_addr, wb_data, out_ready,
    input in_ready, out_valid, reg_s1, reg_s2, out_rd, out_op, enable
  );
endinterface

// File: rtl/operand_fetch_stage_regfile.sv
// regfile_2r1w: register array, async reads, sync write, r0 hardwired to zero, sync clear
module regfile_2r1w
  import operand_fetch_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] mem [NREGS];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && wa != ZERO_REG) begin
      mem[wa] <= wd;
    end
  end
  assign rd1 = ra1 == ZERO_REG ? '0 : mem[ra1];
  assign rd2 = ra2 == ZERO_REG ? '0 : mem[ra2];
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads two operands with write-back bypass into a one-entry valid/ready output register
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input logic clk,
  input logic reset,
  operand_fetch_stage_if.slave bus
);
  state_e state;
  logic [AW-1:0] src1, src2;
  logic [XLEN-1:0] rd1, rd2;
  logic accept, hold;
  regfile_2r1w u_rf (
    .clk(clk),
    .reset(reset),
    .we(bus.wb_en),
    .wa(bus.wb_addr),
    .wd(bus.wb_data),
    .ra1(bus.in_rs1),
    .ra2(bus.in_rs2),
    .rd1(rd1),
    .rd2(rd2)
  );
  assign bus.out_valid = state == FULL;
  assign bus.enable = bus.out_valid;
  assign bus.in_ready = reset || !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  assign hold = bus.out_valid && !bus.out_ready;
  // source indices are retained so a stalled operand tracks later write-backs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      bus.reg_s1 <= '0;
      bus.reg_s2 <= '0;
      bus.out_rd <= '0;
      bus.out_op <= '0;
      src1 <= '0;
      src2 <= '0;
    end else if (accept) begin
      state <= FULL;
      bus.reg_s1 <= wb_hit(bus.wb_en, bus.wb_addr, bus.in_rs1) ? bus.wb_data : rd1;
      bus.reg_s2 <= wb_hit(bus.wb_en, bus.wb_addr, bus.in_rs2) ? bus.wb_data : rd2;
      bus.out_rd <= bus.in_rd;
      bus.out_op <= bus.in_op;
      src1 <= bus.in_rs1;
      src2 <= bus.in_rs2;
    end else if (hold) begin
      if (wb_hit(bus.wb_en, bus.wb_addr, src1)) bus.reg_s1 <= bus.wb_data;
      if (wb_hit(bus.wb_en, bus.wb_addr, src2)) bus.reg_s2 <= bus.wb_data;
    end else begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: randomized + directed scoreboard bench against an architectural register model
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;
  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] op;
  } item_t;
  logic clk = 0;
  logic reset;
  operand_fetch_stage_if bus();
  operand_fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  item_t q[$];
  logic [31:0] regs [32];
  logic after_reset = 0;
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  // operands must always equal the current architectural value of their source registers
  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      chk("enable", {31'd0, bus.enable}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() == 0 || bus.out_ready});
      if (after_reset) begin
        chk("rst_reg_s1", bus.reg_s1, 32'd0);
        chk("rst_reg_s2", bus.reg_s2, 32'd0);
        chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("rst_out_op", {29'd0, bus.out_op}, 32'd0);
        after_reset = 0;
      end
      if (q.size() != 0) begin
        chk("reg_s1", bus.reg_s1, regs[q[0].rs1]);
        chk("reg_s2", bus.reg_s2, regs[q[0].rs2]);
        chk("out_rd", {27'd0, bus.out_rd}, {27'd0, q[0].rd});
        chk("out_op", {29'd0, bus.out_op}, {29'd0, q[0].op});
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end
  task automatic cyc(input logic r, input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input logic [2:0] o, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic ordy);
    logic acc;
    reset = r;
    bus.in_valid = iv;
    bus.in_rs1 = s1;
    bus.in_rs2 = s2;
    bus.in_rd = d;
    bus.in_op = o;
    bus.wb_en = we;
    bus.wb_addr = wa;
    bus.wb_data = wd;
    bus.out_ready = ordy;
    acc = !r && iv && (q.size() == 0 || ordy);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      foreach (regs[i]) regs[i] = '0;
      after_reset = 1;
    end else begin
      if (acc) q.push_back('{s1, s2, d, o});
      if (we && wa != 0) regs[wa] = wd;
    end
  endtask
  task automatic idle(input logic ordy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask
  initial begin
    foreach (regs[i]) regs[i] = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1);
    cyc(0, 1, 5, 0, 1, OP_AND, 0, 0, 0, 1);
    idle(1);
    cyc(0, 1, 7, 7, 2, OP_OR, 1, 7, 32'h12345678, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 32'h1, 1);
    cyc(0, 1, 3, 0, 4, OP_XOR, 0, 0, 0, 0);
    cyc(0, 1, 9, 9, 6, OP_SUB, 1, 3, 32'hFFFF0000, 0);
    cyc(0, 1, 9, 9, 6, OP_SUB, 0, 0, 0, 0);
    idle(1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'hAAAAAAAA, 1);
    cyc(0, 1, 0, 0, 8, OP_NOT, 0, 0, 0, 1);
    cyc(0, 1, 0, 5, 8, OP_ADD, 1, 0, 32'h5555AAAA, 1);
    idle(1);
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 5'(i + 1), 5'(i + 9), 5'(i), 3'(i % 6), 1, 5'(i + 2), $urandom, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 1);
    cyc(0, 1, 5, 5, 3, OP_AND, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 3, OP_AND, 1, 6, 32'h66, 0);
    cyc(0, 1, 5, 6, 1, OP_OR, 0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 3'($urandom_range(0, 5)),
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7);
    idle(1);
    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Register-file read stage directly upstream of the 32-bit bitwise logic units.
- Holds a 2-read/1-write register file and captures an issued instruction's source operands into a one-entry output register.
- Output drives the reg_s1/reg_s2/enable inputs of the logic units through a valid/ready handshake.
- Includes write-back bypass, so operands are never stale.

Parameters:
- XLEN, 32, operand/register data width
- NREGS, 32, number of architectural registers
- AW, 5, register index width (log2 NREGS)
- OPW, 3, operation-select width passed through to the execute units

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  issue request valid
- in_ready  output  1  stage can accept an issue this cycle
- in_rs1  input  AW  source register 1 index
- in_rs2  input  AW  source register 2 index
- in_rd  input  AW  destination index, passed through
- in_op  input  OPW  operation select, passed through
- wb_en  input  1  write-back enable
- wb_addr  input  AW  write-back register index
- wb_data  input  XLEN  write-back data
- out_valid  output  1  operands valid toward execute
- out_ready  input  1  execute accepts operands
- reg_s1  output  XLEN  operand 1
- reg_s2  output  XLEN  operand 2
- out_rd  output  AW  captured destination index
- out_op  output  OPW  captured operation select
- enable  output  1  execute enable; equals out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset: all registers cleared to 0; out_valid=0; reg_s1, reg_s2, out_rd, out_op = 0; enable=0.
- Register file:
  - Register 0 reads as 0 and ignores writes.
  - Writes commit at the clock edge when wb_en=1 and wb_addr!=0.
- in_ready = !out_valid || out_ready. This is combinational and is 1 during reset.
- Accept: when in_valid && in_ready, operands are read and captured into the output register at the edge. out_valid=1 the next cycle, giving 1-cycle latency.
- Bypass: if wb_en=1 && wb_addr==rsN && rsN!=0 in the accept cycle, the captured operand is wb_data, not the old array value.
- Hold: while out_valid && !out_ready, all outputs are stable, except for held-operand update.
- Held-operand update: while holding, a write with wb_addr equal to a captured nonzero source index overwrites that captured operand (reg_s1, reg_s2 or both) at the edge. The captured source indices are kept internally for this.
- Drain: out_ready && out_valid && !(in_valid) → out_valid=0 next cycle. reg_s1/reg_s2/out_rd/out_op keep their last values (don't-care for the consumer).
- Back-to-back: out_ready=1 with in_valid=1 every cycle gives one operand set per cycle with no bubbles.
- Simultaneous write and read of register 0: the read returns 0.
- Reset mid-operation: reset dominates the handshake and write-back. The outstanding operand set is dropped, and a write in the reset cycle is discarded.
- State is two-state in effect: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with out_ready, or on stall.
  - FULL→EMPTY on out_ready with no accept.

Decomposition:
- Shared package holds:
  - XLEN, NREGS, AW, OPW defaults.
  - Operation encodings OP_AND=3'd0, OP_OR=3'd1, OP_XOR=3'd2, OP_NOT=3'd3, OP_ADD=3'd4, OP_SUB=3'd5.
  - The zero-register index constant.
- One sub-module, regfile_2r1w: the register array with asynchronous reads, synchronous write, register-0 masking and synchronous clear.
- Bypass, hold-update and handshake logic live in operand_fetch_stage.

Test Plan:
- Reset, then read: write r5=0xDEADBEEF, then issue rs1=5, rs2=0 → next cycle reg_s1=0xDEADBEEF, reg_s2=0, enable=1.
- Same-cycle bypass: wb r7=0x12345678 in the same cycle as an issue of rs1=7, rs2=7 → reg_s1=reg_s2=0x12345678.
- Stall with update: capture rs1=3 (value 0x1), hold out_ready=0, then wb r3=0xFFFF0000 → reg_s1=0xFFFF0000 while stalled, in_ready=0, and out_rd/out_op unchanged.
- Register 0 write: wb r0=0xAAAAAAAA, then issue rs1=0 → reg_s1=0.
- Streaming: 8 consecutive issues with out_ready=1 → 8 consecutive out_valid cycles, operands in order, no bubbles.
- Reset mid-stall: out_valid=1 and stalled, then reset for 1 cycle → out_valid=0, reg_s1=0, and r5 reads 0 afterward.
